// File: rtl/mem_stage_if.sv
// EX -> MEM -> WB bundle for the MEM pipeline stage.
// The slave side is the MEM stage; the master side is the EX stage and the WB/forwarding consumers.
interface mem_stage_if #(
   parameter int DATA_W = 32,
   parameter int RA_W   = 5
);
   logic              stall;
   logic [DATA_W-1:0] ALUoutputData_ex;
   logic [DATA_W-1:0] rtData_ex;
   logic [RA_W-1:0]   RegFileWtAddr_ex;
   logic              wmem_ex;
   logic              Mem2Reg_ex;
   logic              wreg_ex;

   logic [DATA_W-1:0] RegFileWtData_mem;
   logic [RA_W-1:0]   RegFileWtAddr_mem;
   logic              wreg_mem;
   logic              addr_err_mem;

   modport master (
      output stall, ALUoutputData_ex, rtData_ex, RegFileWtAddr_ex,
             wmem_ex, Mem2Reg_ex, wreg_ex,
      input  RegFileWtData_mem, RegFileWtAddr_mem, wreg_mem, addr_err_mem
   );

   modport slave (
      input  stall, ALUoutputData_ex, rtData_ex, RegFileWtAddr_ex,
             wmem_ex, Mem2Reg_ex, wreg_ex,
      output RegFileWtData_mem, RegFileWtAddr_mem, wreg_mem, addr_err_mem
   );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: word-addressed data memory for LW/SW plus the MEM/WB pipeline register.
// Misaligned accesses are flagged and never write memory or the register file.
module mem_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8,
   parameter int RA_W   = 5
) (
   input  logic        i_clk,
   input  logic        i_rst,
   mem_stage_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic [DATA_W-1:0] r_wb_data;
   logic [RA_W-1:0]   r_wb_addr;
   logic              r_wb_wreg;
   logic              r_wb_err;

   logic [ADDR_W-1:0] w_idx;
   logic              w_aligned;
   logic              w_is_access;
   logic              w_mem_we;
   logic [DATA_W-1:0] w_rd_data;
   logic [DATA_W-1:0] w_wb_data;
   logic              w_wb_wreg;
   logic              w_wb_err;

   // Byte address -> word index; upper address bits wrap modulo the memory depth.
   assign w_idx       = bus.ALUoutputData_ex[ADDR_W+1:2];
   assign w_aligned   = (bus.ALUoutputData_ex[1:0] == 2'b00);
   assign w_is_access = bus.wmem_ex | bus.Mem2Reg_ex;
   assign w_mem_we    = bus.wmem_ex & w_aligned & ~bus.stall & ~i_rst;
   assign w_rd_data   = r_mem[w_idx];

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      w_wb_data = bus.ALUoutputData_ex;
      if (bus.Mem2Reg_ex) begin
         w_wb_data = w_aligned ? w_rd_data : '0;
      end
      // Stores (including the illegal store+load encoding) never write the register file.
      w_wb_wreg = bus.wreg_ex & ~bus.wmem_ex & ~(bus.Mem2Reg_ex & ~w_aligned);
      w_wb_err  = w_is_access & ~w_aligned;
   end

   // NOTE: the data memory has no reset; contents survive rst and only the pipeline register clears.
   always_ff @(posedge i_clk) begin
      if (w_mem_we) begin
         r_mem[w_idx] <= bus.rtData_ex;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wb_data <= '0;
         r_wb_addr <= '0;
         r_wb_wreg <= 1'b0;
         r_wb_err  <= 1'b0;
      end else if (!bus.stall) begin
         r_wb_data <= w_wb_data;
         r_wb_addr <= bus.RegFileWtAddr_ex;
         r_wb_wreg <= w_wb_wreg;
         r_wb_err  <= w_wb_err;
      end
   end

   assign bus.RegFileWtData_mem = r_wb_data;
   assign bus.RegFileWtAddr_mem = r_wb_addr;
   assign bus.wreg_mem          = r_wb_wreg;
   assign bus.addr_err_mem      = r_wb_err;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: each driven step pushes its expected MEM/WB value,
// which is popped and compared one cycle later against the DUT outputs.
module tb_mem_stage;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 8;
   localparam int RA_W   = 5;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [RA_W-1:0]   addr;
      logic              wreg;
      logic              err;
   } wb_t;

   typedef struct {
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] rt;
      logic [RA_W-1:0]   rd;
      logic              wmem;
      logic              m2r;
      logic              wreg;
      logic              stall;
      logic              rst;
   } step_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_stage_if #(.DATA_W(DATA_W), .RA_W(RA_W)) bus ();

   mem_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RA_W(RA_W)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   logic [DATA_W-1:0] model_mem [1 << ADDR_W];
   wb_t exp_q [$];
   wb_t last_exp;
   int  passed = 0;
   int  total  = 0;

   function automatic step_t mk(logic [DATA_W-1:0] alu, logic [DATA_W-1:0] rt, logic [RA_W-1:0] rd,
                                logic wmem, logic m2r, logic wreg, logic stall, logic rst_v);
      step_t s;
      s.alu = alu; s.rt = rt; s.rd = rd; s.wmem = wmem; s.m2r = m2r;
      s.wreg = wreg; s.stall = stall; s.rst = rst_v;
      return s;
   endfunction

   function automatic wb_t observe();
      wb_t o;
      o.data = bus.RegFileWtData_mem;
      o.addr = bus.RegFileWtAddr_mem;
      o.wreg = bus.wreg_mem;
      o.err  = bus.addr_err_mem;
      return o;
   endfunction

   // Drive one EX-stage step, push its expected MEM/WB result, advance past the edge.
   task automatic drive(input step_t s);
      wb_t e;
      logic aligned;
      logic [ADDR_W-1:0] idx;
      aligned = (s.alu[1:0] == 2'b00);
      idx     = s.alu[ADDR_W+1:2];
      bus.ALUoutputData_ex = s.alu;
      bus.rtData_ex        = s.rt;
      bus.RegFileWtAddr_ex = s.rd;
      bus.wmem_ex          = s.wmem;
      bus.Mem2Reg_ex       = s.m2r;
      bus.wreg_ex          = s.wreg;
      bus.stall            = s.stall;
      rst                  = s.rst;
      if (s.rst) begin
         e = '0;
      end else if (s.stall) begin
         e = last_exp;
      end else begin
         e.data = s.m2r ? (aligned ? model_mem[idx] : '0) : s.alu;
         e.addr = s.rd;
         e.wreg = s.wreg && !s.wmem && !(s.m2r && !aligned);
         e.err  = (s.wmem || s.m2r) && !aligned;
         if (s.wmem && aligned) model_mem[idx] = s.rt;
      end
      last_exp = e;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step_t t[3];
      wb_t o, e;
      t[0] = mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      t[1] = mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      t[2] = mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      foreach (t[i]) begin
         drive(t[i]);
         o = observe(); e = exp_q.pop_front(); total++;
         if (o !== e) $display("FAIL reset[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                               i, o.data, o.addr, o.wreg, o.err, e.data, e.addr, e.wreg, e.err);
         else passed++;
      end
   endtask

   task automatic test_sw_lw_alu();
      step_t t[3];
      wb_t o, e;
      t[0] = mk(32'h10, 32'hDEADBEEF, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      t[1] = mk(32'h10, 32'h0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      t[2] = mk(32'h1234, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      foreach (t[i]) begin
         drive(t[i]);
         o = observe(); e = exp_q.pop_front(); total++;
         if (o !== e) $display("FAIL sw_lw_alu[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                               i, o.data, o.addr, o.wreg, o.err, e.data, e.addr, e.wreg, e.err);
         else passed++;
      end
   endtask

   task automatic test_misaligned();
      step_t t[4];
      wb_t o, e;
      t[0] = mk(32'h13, 32'h55, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      t[1] = mk(32'h10, 32'h0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      t[2] = mk(32'h12, 32'h0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      t[3] = mk(32'h11, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      foreach (t[i]) begin
         drive(t[i]);
         o = observe(); e = exp_q.pop_front(); total++;
         if (o !== e) $display("FAIL misaligned[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                               i, o.data, o.addr, o.wreg, o.err, e.data, e.addr, e.wreg, e.err);
         else passed++;
      end
   endtask

   task automatic test_wrap_illegal();
      step_t t[5];
      wb_t o, e;
      t[0] = mk(32'h400, 32'hA5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      t[1] = mk(32'h0, 32'h0, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      t[2] = mk(32'h30, 32'h11, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      t[3] = mk(32'h30, 32'h77, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      t[4] = mk(32'h30, 32'h0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      foreach (t[i]) begin
         drive(t[i]);
         o = observe(); e = exp_q.pop_front(); total++;
         if (o !== e) $display("FAIL wrap_illegal[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                               i, o.data, o.addr, o.wreg, o.err, e.data, e.addr, e.wreg, e.err);
         else passed++;
      end
   endtask

   task automatic test_stall_reset();
      step_t t[7];
      wb_t o, e;
      t[0] = mk(32'h20, 32'h99, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      t[1] = mk(32'h5A5A, 32'h0, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      t[2] = mk(32'h20, 32'h7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      t[3] = mk(32'h20, 32'h0, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      t[4] = mk(32'h20, 32'h3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      t[5] = mk(32'h20, 32'h0, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      t[6] = mk(32'h10, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      foreach (t[i]) begin
         drive(t[i]);
         o = observe(); e = exp_q.pop_front(); total++;
         if (o !== e) $display("FAIL stall_reset[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                               i, o.data, o.addr, o.wreg, o.err, e.data, e.addr, e.wreg, e.err);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] a;
      wb_t o, e;
      for (int i = 0; i < 16; i++) begin
         a = 32'h100 + 32'(i % 8) * 4 + ((i < 8) ? 32'h0 : 32'h1000);
         if (i < 8) drive(mk(a, $urandom, 5'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
         else       drive(mk(a, 32'h0, 5'(i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
         o = observe(); e = exp_q.pop_front(); total++;
         if (o !== e) $display("FAIL back_to_back[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                               i, o.data, o.addr, o.wreg, o.err, e.data, e.addr, e.wreg, e.err);
         else passed++;
      end
   endtask

   initial begin
      rst                  = 1'b1;
      bus.stall            = 1'b0;
      bus.ALUoutputData_ex = '0;
      bus.rtData_ex        = '0;
      bus.RegFileWtAddr_ex = '0;
      bus.wmem_ex          = 1'b0;
      bus.Mem2Reg_ex       = 1'b0;
      bus.wreg_ex          = 1'b0;
      last_exp             = '0;
      @(negedge clk);
      test_reset();
      test_sw_lw_alu();
      test_misaligned();
      test_wrap_illegal();
      test_stall_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
